// File: rtl/mlaccel_qpi_host.sv
// ============================================================================
//  Module   : mlaccel_qpi_host
//  Purpose  : QPI initiator. Serialises a byte command stream onto
//             qpi_csb/qpi_clk/io and returns read bytes as rsp pulses.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mlaccel_qpi_host #(
  parameter int HALF_PERIOD = 4,
  parameter int CS_SETUP    = 4,
  parameter int CS_GAP      = 8
) (
  input  logic       clock,
  input  logic       resetn,
  output logic       qpi_csb,
  output logic       qpi_clk,
  input  logic [3:0] qpi_io_di,
  output logic [3:0] qpi_io_do,
  output logic [3:0] qpi_io_oe,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_read,
  input  logic       cmd_last,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy
);

  localparam int MAX_A = (HALF_PERIOD > CS_SETUP) ? HALF_PERIOD : CS_SETUP;
  localparam int MAX_P = (MAX_A > CS_GAP) ? MAX_A : CS_GAP;
  localparam int CW    = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] HP_LOAD    = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] SETUP_LOAD = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(CS_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_LO    = 3'd2,
    S_HI    = 3'd3,
    S_WAIT  = 3'd4,
    S_END   = 3'd5,
    S_GAP   = 3'd6
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0]    byte_data;
  logic          byte_read;
  logic          byte_last;
  logic          read_seen;
  logic          load;
  logic          cnt_zero;
  logic          drive;

  assign cnt_zero = (cnt == '0);

  // Next-state, counter reload and handshake decode
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_zero ? cnt : cnt - CW'(1);
    cmd_ready = 1'b0;
    load      = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          load      = 1'b1;
          state_nxt = S_SETUP;
          cnt_nxt   = SETUP_LOAD;
        end
      end
      S_SETUP: if (cnt_zero) begin
        state_nxt = S_LO;
        cnt_nxt   = HP_LOAD;
      end
      S_LO: if (cnt_zero) begin
        state_nxt = S_HI;
        cnt_nxt   = HP_LOAD;
      end
      S_HI: if (cnt_zero) begin
        state_nxt = byte_last ? S_END : S_WAIT;
        cnt_nxt   = HP_LOAD;
      end
      S_WAIT: begin
        // Once the device has turned the bus around it keeps driving io until
        // csb rises, so a write after a read must start a new transaction.
        cmd_ready = !(read_seen && !cmd_read);
        if (cmd_valid) begin
          cnt_nxt = HP_LOAD;
          if (cmd_ready) begin
            load      = 1'b1;
            state_nxt = S_LO;
          end else begin
            state_nxt = S_END;
          end
        end
      end
      S_END: if (cnt_zero) begin
        state_nxt = S_GAP;
        cnt_nxt   = GAP_LOAD;
      end
      S_GAP: if (cnt_zero) begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, counter and byte register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      byte_data <= 8'h00;
      byte_read <= 1'b0;
      byte_last <= 1'b0;
      read_seen <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load) begin
        byte_data <= cmd_data;
        byte_read <= cmd_read;
        byte_last <= cmd_last;
      end
      if (load && state == S_IDLE) begin
        read_seen <= 1'b0;
      end else if (state == S_HI && cnt_zero && byte_read) begin
        read_seen <= 1'b1;
      end
    end
  end

  // Read-data capture at the end of each clock phase, pulse after the byte
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
    end else begin
      rsp_valid <= (state == S_HI) && cnt_zero && byte_read;
      if (state == S_LO && cnt_zero && byte_read) begin
        rsp_data[7:4] <= qpi_io_di;
      end
      if (state == S_HI && cnt_zero && byte_read) begin
        rsp_data[3:0] <= qpi_io_di;
      end
    end
  end

  // Pad outputs decoded from state so reset releases the bus immediately
  always_comb begin
    qpi_csb = (state == S_IDLE) || (state == S_GAP);
    qpi_clk = (state == S_HI);
    busy    = (state != S_IDLE);
    drive   = !byte_read &&
              ((state == S_SETUP) || (state == S_LO) ||
               (state == S_HI)    || (state == S_WAIT));
    qpi_io_oe = {4{drive}};
    if (!drive) begin
      qpi_io_do = 4'h0;
    end else if (state == S_HI || state == S_WAIT) begin
      qpi_io_do = byte_data[3:0];
    end else begin
      qpi_io_do = byte_data[7:4];
    end
  end

  // Reject timings too fast for the device's 3-flop synchroniser and edge detect
  always_ff @(posedge clock) begin
    assert (HALF_PERIOD >= 4 && CS_GAP >= 4 && CS_SETUP >= 1)
      else $error("mlaccel_qpi_host: illegal timing parameters");
  end

endmodule

`default_nettype wire
